// File: rtl/serial_frame_pkg.sv
// Shared types and defaults for the serial frame deserializer.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2
  } state_t;

  localparam int                    DEF_W      = 4;
  localparam int                    DEF_SYNC_W = 4;
  localparam logic [DEF_SYNC_W-1:0] DEF_SYNC   = 4'b1011;

endpackage

// File: rtl/frame_bit_counter.sv
// Data-bit counter for one frame: synchronous clear, increment on enable,
// saturating at W-1 where the terminal-count flag is raised.
module frame_bit_counter
  import serial_frame_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic clk,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = $clog2(W);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (inc && !tc)
      cnt <= cnt + CW'(1);
  end

  assign tc = (cnt == CW'(W - 1));

endmodule

// File: rtl/serial_frame_deserializer.sv
// Hunts for a sync pattern on SI, then assembles the next W bits MSB first into Q.
// Optional even-parity check on a trailing bit is enabled by defining PARITY_CHECK_EN.
module serial_frame_deserializer
  import serial_frame_pkg::*;
#(
  parameter int                W      = DEF_W,
  parameter int                SYNC_W = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC   = DEF_SYNC
) (
  input  logic         C,
  input  logic         R,
  input  logic         EN,
  input  logic         SI,
  output logic [W-1:0] Q,
  output logic         V,
  output logic         LOCK,
  output logic         ERR
);

  state_t            state, state_nxt;
  logic [SYNC_W-1:0] win, win_nxt;
  logic [W-1:0]      word, word_nxt;
  logic [W-1:0]      q_nxt;
  logic              v_nxt;
  logic              cnt_clr, cnt_inc, cnt_tc;
`ifdef PARITY_CHECK_EN
  logic              err_q, err_nxt;
`endif

  // Counter sits at zero for the whole hunt, so every frame starts from a clean count.
  assign cnt_clr = R || (state == ST_HUNT);
  assign cnt_inc = EN && (state == ST_DATA);

  frame_bit_counter #(.W(W)) u_cnt (
    .clk (C),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (cnt_tc)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_nxt = state;
    win_nxt   = win;
    word_nxt  = word;
    q_nxt     = Q;
    v_nxt     = 1'b0;
`ifdef PARITY_CHECK_EN
    err_nxt   = 1'b0;
`endif
    if (EN) begin
      case (state)
        ST_HUNT: begin
          win_nxt = {win[SYNC_W-2:0], SI};
          if (win_nxt == SYNC)
            state_nxt = ST_DATA;
        end
        ST_DATA: begin
          word_nxt = {word[W-2:0], SI};
          if (cnt_tc) begin
`ifdef PARITY_CHECK_EN
            state_nxt = ST_PAR;
`else
            q_nxt     = word_nxt;
            v_nxt     = 1'b1;
            state_nxt = ST_HUNT;
            win_nxt   = '0;
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        ST_PAR: begin
          // Even parity: the data ones plus the parity bit must total an even count.
          if ((^word) == SI) begin
            q_nxt = word;
            v_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
          state_nxt = ST_HUNT;
          win_nxt   = '0;
        end
`endif
        default: begin
          state_nxt = ST_HUNT;
          win_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge C) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (R) begin
      state <= ST_HUNT;
      win   <= '0;
      word  <= '0;
      Q     <= '0;
      V     <= 1'b0;
`ifdef PARITY_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      win   <= win_nxt;
      word  <= word_nxt;
      Q     <= q_nxt;
      V     <= v_nxt;
`ifdef PARITY_CHECK_EN
      err_q <= err_nxt;
`endif
    end
  end

  assign LOCK = (state != ST_HUNT);

`ifdef PARITY_CHECK_EN
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench for serial_frame_deserializer with a queue scoreboard of expected words.
module tb_serial_frame_deserializer;

`ifdef PARITY_CHECK_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic       C = 1'b0;
  logic       R, EN, SI;
  logic [3:0] Q;
  logic       V, LOCK, ERR;

  int         total  = 0;
  int         passed = 0;
  int         failed = 0;
  logic [3:0] sb[$];
  logic [3:0] exp_q;

  serial_frame_deserializer dut (
    .C    (C),
    .R    (R),
    .EN   (EN),
    .SI   (SI),
    .Q    (Q),
    .V    (V),
    .LOCK (LOCK),
    .ERR  (ERR)
  );

  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, then check the pulses that must follow that edge.
  // pulse: 0 = none, 1 = V, 2 = ERR.
  task automatic step(input logic en, input logic si, input int pulse, input string tag);
    @(negedge C);
    EN = en;
    SI = si;
    @(posedge C);
    #1;
    check({tag, "/V"},   32'(V),   32'(pulse == 1));
    check({tag, "/ERR"}, 32'(ERR), 32'(pulse == 2));
    if (V === 1'b1) begin
      check({tag, "/sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_q = sb.pop_front();
        check({tag, "/Q"}, 32'(Q), 32'(exp_q));
      end
    end
  endtask

  task automatic do_reset(input int n, input string tag);
    @(negedge C);
    R  = 1'b1;
    EN = 1'b1;
    SI = 1'b1;
    repeat (n) @(posedge C);
    #1;
    check({tag, "/Q"},    32'(Q),    32'd0);
    check({tag, "/V"},    32'(V),    32'd0);
    check({tag, "/ERR"},  32'(ERR),  32'd0);
    check({tag, "/LOCK"}, 32'(LOCK), 32'd0);
    @(negedge C);
    R     = 1'b0;
    EN    = 1'b0;
    exp_q = '0;
    sb.delete();
  endtask

  // Hunt-phase bits, MSB first; lock must appear only after the final bit.
  task automatic send_hunt(input logic [15:0] bits, input int n, input bit gap, input string tag);
    logic b;
    for (int i = n - 1; i >= 0; i--) begin
      b = bits[i];
      step(1'b1, b, 0, tag);
      check({tag, "/LOCK"}, 32'(LOCK), 32'(i == 0));
      if (gap) begin
        step(1'b0, ~b, 0, tag);
        check({tag, "/LOCK_gap"}, 32'(LOCK), 32'(i == 0));
      end
    end
  endtask

  task automatic send_data(input logic [3:0] data, input bit par_ok, input bit gap, input string tag);
    logic b;
    if (par_ok || !HAS_PAR)
      sb.push_back(data);
    for (int i = 3; i >= 0; i--) begin
      b = data[i];
      step(1'b1, b, (i == 0 && !HAS_PAR) ? 1 : 0, tag);
      if (gap) begin
        step(1'b0, ~b, 0, tag);
        check({tag, "/LOCK_gap"}, 32'(LOCK), 32'(i != 0 || HAS_PAR));
      end
    end
    if (HAS_PAR) begin
      b = par_ok ? (^data) : ~(^data);
      step(1'b1, b, par_ok ? 1 : 2, tag);
      if (!par_ok)
        check({tag, "/Q_hold"}, 32'(Q), 32'(exp_q));
      if (gap)
        step(1'b0, ~b, 0, tag);
    end
    check({tag, "/LOCK_end"}, 32'(LOCK), 32'd0);
  endtask

  task automatic send_frame(input logic [3:0] data, input bit par_ok, input bit gap, input string tag);
    send_hunt(16'b1011, 4, gap, tag);
    send_data(data, par_ok, gap, tag);
  endtask

  initial begin
    R     = 1'b1;
    EN    = 1'b0;
    SI    = 1'b0;
    exp_q = '0;

    do_reset(2, "reset_init");

    send_frame(4'b1100, 1'b1, 1'b0, "basic");
    send_frame(4'b1100, 1'b1, 1'b1, "gapped");

    // Overlapping candidates: lock on the second one.
    send_hunt(16'b101011, 6, 1'b0, "overlap");
    send_data(4'b0110, 1'b1, 1'b0, "overlap");

    send_frame(4'b1110, 1'b1, 1'b0, "par_good");
    if (HAS_PAR)
      send_frame(4'b1110, 1'b0, 1'b0, "par_bad");

    // Reset two data bits into a frame.
    send_hunt(16'b1011, 4, 1'b0, "mid_reset");
    step(1'b1, 1'b1, 0, "mid_reset");
    step(1'b1, 1'b0, 0, "mid_reset");
    check("mid_reset/LOCK_pre", 32'(LOCK), 32'd1);
    do_reset(2, "mid_reset");
    send_frame(4'b0110, 1'b1, 1'b0, "after_reset");

    // Back-to-back frames; the first frame's data looks like a sync pattern.
    send_frame(4'b1011, 1'b1, 1'b0, "b2b_1");
    send_frame(4'b1101, 1'b1, 1'b0, "b2b_2");

    // Tail bits after a frame must not combine with stale window contents.
    send_hunt(16'b0111011, 7, 1'b0, "clean_window");
    send_data(4'b1001, 1'b1, 1'b0, "clean_window");

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
